lsu_access_fsm: RTL and testbench

//  Parametrised memory-access stage between EXU and WB. Per load/store: one data-bus

---
 rtl/lsu_access_fsm_pkg.sv | 38 +++
 rtl/lsu_lane_align.sv | 43 ++++
 rtl/lsu_access_fsm.sv | 133 +++++++++++++
 tb/tb_lsu_access_fsm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_access_fsm_pkg.sv
// Shared types and helpers for the load/store access stage.
package lsu_access_fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  typedef enum logic [2:0] {
    MI_B   = 3'd0,
    MI_H   = 3'd1,
    MI_W   = 3'd2,
    MI_D   = 3'd3,
    MI_BU  = 3'd4,
    MI_HU  = 3'd5,
    MI_WU  = 3'd6,
    MI_ILL = 3'd7
  } mem_info_e;

  // Byte-enable pattern for an access of 2**size bytes at offset 0.
  function automatic logic [15:0] size_byte_mask(logic [1:0] size);
    return 16'((17'd1 << (4'd1 << size)) - 17'd1);
  endfunction

  function automatic logic addr_aligned(logic [2:0] addr_lo, logic [1:0] size);
    logic [2:0] m;
    m = 3'((4'd1 << size) - 4'd1);
    return (addr_lo & m) == 3'b000;
  endfunction

  function automatic logic info_legal(logic [2:0] info, int data_w);
    return (mem_info_e'(info) != MI_ILL) &&
           !((mem_info_e'(info) == MI_D) && (data_w == 32));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobe/shift and load slice with sign/zero extension.
module lsu_lane_align
  import lsu_access_fsm_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [OFF_W-1:0]    offset,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W/8-1:0] strobe,
  output logic [DATA_W-1:0]   wdata_sh,
  output logic [DATA_W-1:0]   rdata_ext
);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] rdata_sh;
  logic [DATA_W-1:0] keep;
  logic              neg;
  int unsigned       shamt;

  assign strobe   = STRB_W'(size_byte_mask(size)) << offset;
  assign wdata_sh = wdata << {offset, 3'b000};

  // keep saturates to all-ones when the access covers the whole bus
  always_comb begin
    rdata_sh = rdata >> {offset, 3'b000};
    shamt    = 32'd8 << size;
    keep     = (DATA_W'(1) << shamt) - DATA_W'(1);
    neg      = 1'b0;
    case (size)
      2'd0:    neg = rdata_sh[7];
      2'd1:    neg = rdata_sh[15];
      2'd2:    neg = rdata_sh[31];
      default: neg = rdata_sh[DATA_W-1];
    endcase
    neg       = neg & sign_ext;
    rdata_ext = (rdata_sh & keep) | ({DATA_W{neg}} & ~keep);
  end

endmodule

// File: rtl/lsu_access_fsm.sv
// Memory-access stage: one bus transaction per load/store, with trap, kill and MMIO flag.
module lsu_access_fsm
  import lsu_access_fsm_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 64,
  parameter int MMIO_BIT = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [2:0]          info_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rd_wdata_i,
  input  logic                flush_i,
  output logic                dreq_valid_o,
  output logic [ADDR_W-1:0]   dreq_addr_o,
  output logic [2:0]          dreq_size_o,
  output logic [DATA_W/8-1:0] dreq_strobe_o,
  output logic [DATA_W-1:0]   dreq_data_o,
  input  logic                dresp_addr_ok_i,
  input  logic                dresp_data_ok_i,
  input  logic [DATA_W-1:0]   dresp_data_i,
  output logic [DATA_W-1:0]   rd_wdata_o,
  output logic                done_o,
  output logic                exc_o,
  output logic                skip_o,
  output logic                stall_req_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  lsu_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              we_q;
  logic              mmio_q;
  logic              kill_q;
  logic [STRB_W-1:0] strobe_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              legal;
  logic              accept;
  logic              capture;
  logic [1:0]        al_size;
  logic [OFF_W-1:0]  al_off;
  logic [STRB_W-1:0] al_strobe;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;

  assign legal   = info_legal(info_i, DATA_W) && addr_aligned(addr_i[2:0], info_i[1:0]);
  assign accept  = (state_q == S_IDLE) && req_i && !flush_i && legal;
  assign capture = ((state_q == S_REQ) && dresp_addr_ok_i && dresp_data_ok_i) ||
                   ((state_q == S_WAIT) && dresp_data_ok_i);

  // One aligner serves both directions: IDLE uses the incoming op, later states the latched one.
  assign al_size = (state_q == S_IDLE) ? info_i[1:0] : size_q;
  assign al_off  = (state_q == S_IDLE) ? addr_i[OFF_W-1:0] : addr_q[OFF_W-1:0];

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size      (al_size),
    .sign_ext  (sign_q),
    .offset    (al_off),
    .wdata     (wdata_i),
    .rdata     (dresp_data_i),
    .strobe    (al_strobe),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ:  if (dresp_addr_ok_i) state_d = dresp_data_ok_i ? S_DONE : S_WAIT;
      S_WAIT: if (dresp_data_ok_i) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      size_q   <= '0;
      sign_q   <= 1'b0;
      we_q     <= 1'b0;
      mmio_q   <= 1'b0;
      kill_q   <= 1'b0;
      strobe_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= addr_i;
        size_q   <= info_i[1:0];
        sign_q   <= ~info_i[2];
        we_q     <= we_i;
        mmio_q   <= ~addr_i[MMIO_BIT];
        kill_q   <= 1'b0;
        strobe_q <= we_i ? al_strobe : '0;
        wdata_q  <= we_i ? al_wdata : '0;
      end
      if ((state_q == S_REQ) || (state_q == S_WAIT)) kill_q <= kill_q | flush_i;
      if (state_q == S_DONE) kill_q <= 1'b0;
      if (capture) rdata_q <= al_rdata;
    end
  end

  always_comb begin
    dreq_valid_o  = (state_q == S_REQ);
    dreq_addr_o   = addr_q;
    dreq_size_o   = {1'b0, size_q};
    dreq_strobe_o = strobe_q;
    dreq_data_o   = wdata_q;
    stall_req_o   = accept || (state_q == S_REQ) || (state_q == S_WAIT);
    exc_o         = (state_q == S_IDLE) && req_i && !flush_i && !legal;
    done_o        = (state_q == S_DONE) && !kill_q;
    skip_o        = (state_q == S_DONE) && mmio_q && !kill_q;
    rd_wdata_o    = ((state_q == S_DONE) && !we_q) ? rdata_q : rd_wdata_i;
  end

endmodule

// File: tb/tb_lsu_access_fsm.sv
// Vector table plus scoreboard bench for the memory-access stage.
module tb_lsu_access_fsm;
  localparam logic [63:0] RDP = 64'h0123_4567_89AB_CDEF;
  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, flush_i;
  logic [2:0]  info_i;
  logic [63:0] addr_i, wdata_i, rd_wdata_i;
  logic        dreq_valid_o;
  logic [63:0] dreq_addr_o;
  logic [2:0]  dreq_size_o;
  logic [7:0]  dreq_strobe_o;
  logic [63:0] dreq_data_o;
  logic        dresp_addr_ok_i, dresp_data_ok_i;
  logic [63:0] dresp_data_i;
  logic [63:0] rd_wdata_o;
  logic        done_o, exc_o, skip_o, stall_req_o;

  lsu_access_fsm #(.DATA_W(64), .ADDR_W(64), .MMIO_BIT(31)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .info_i(info_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_wdata_i(rd_wdata_i), .flush_i(flush_i),
    .dreq_valid_o(dreq_valid_o), .dreq_addr_o(dreq_addr_o), .dreq_size_o(dreq_size_o),
    .dreq_strobe_o(dreq_strobe_o), .dreq_data_o(dreq_data_o),
    .dresp_addr_ok_i(dresp_addr_ok_i), .dresp_data_ok_i(dresp_data_ok_i),
    .dresp_data_i(dresp_data_i), .rd_wdata_o(rd_wdata_o), .done_o(done_o),
    .exc_o(exc_o), .skip_o(skip_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  info;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        exc;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [63:0] data;
    logic [63:0] rd;
    logic        skip;
  } vec_t;

  typedef struct {
    logic        is_exc;
    logic [63:0] rd;
    logic        skip;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every done_o/exc_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && (done_o === 1'b1 || exc_o === 1'b1)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 64'({done_o, exc_o}), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("exc_pulse", 64'(exc_o), 64'(e.is_exc));
        chk("done_pulse", 64'(done_o), 64'(!e.is_exc));
        if (!e.is_exc) begin
          chk("rd_wdata", rd_wdata_o, e.rd);
          chk("skip", 64'(skip_o), 64'(e.skip));
        end
      end
    end
  end

  task automatic run_op(input vec_t v, input int addr_dly, input int data_dly, input bit flush_wait);
    exp_t e;
    bit   killed;
    killed = flush_wait && (data_dly > 0);
    if (!killed) begin
      e.is_exc = v.exc;
      e.rd     = v.rd;
      e.skip   = v.skip;
      sb_q.push_back(e);
    end
    req_i = 1'b1; we_i = v.we; info_i = v.info; addr_i = v.addr; wdata_i = v.wdata;
    @(negedge clk);
    chk("stall_idle", 64'(stall_req_o), 64'(!v.exc));
    chk("valid_idle", 64'(dreq_valid_o), 64'd0);
    @(posedge clk); #1;
    if (v.exc) begin
      req_i = 1'b0;
      @(negedge clk);
      chk("valid_after_exc", 64'(dreq_valid_o), 64'd0);
      chk("stall_after_exc", 64'(stall_req_o), 64'd0);
      @(posedge clk); #1;
      return;
    end
    for (int k = 0; k <= addr_dly; k++) begin
      if (k == addr_dly) begin
        dresp_addr_ok_i = 1'b1;
        dresp_data_ok_i = (data_dly == 0);
        dresp_data_i    = v.rdata;
      end
      @(negedge clk);
      chk("req_valid", 64'(dreq_valid_o), 64'd1);
      chk("req_addr", dreq_addr_o, v.addr);
      chk("req_size", 64'(dreq_size_o), 64'(v.size));
      chk("req_strobe", 64'(dreq_strobe_o), 64'(v.strb));
      chk("req_data", dreq_data_o, v.data);
      chk("req_stall", 64'(stall_req_o), 64'd1);
      @(posedge clk); #1;
      dresp_addr_ok_i = 1'b0;
      dresp_data_ok_i = 1'b0;
      dresp_data_i    = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    for (int k = 1; k <= data_dly; k++) begin
      dresp_data_ok_i = (k == data_dly);
      dresp_data_i    = (k == data_dly) ? v.rdata : 64'hBAD0_BAD0_BAD0_BAD0;
      flush_i         = flush_wait && (k == 1);
      @(negedge clk);
      chk("wait_valid", 64'(dreq_valid_o), 64'd0);
      chk("wait_stall", 64'(stall_req_o), 64'd1);
      @(posedge clk); #1;
      dresp_data_ok_i = 1'b0;
      flush_i         = 1'b0;
    end
    req_i = 1'b0;
    @(negedge clk);
    chk("done_stall", 64'(stall_req_o), 64'd0);
    if (killed) begin
      chk("killed_done", 64'(done_o), 64'd0);
      chk("killed_skip", 64'(skip_o), 64'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", 64'(done_o), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          we    info  addr                   wdata                  rdata                  exc   size  strb   data                   rd                     skip
    vecs[0]  = '{1'b0, 3'd2, 64'h0000_0000_8000_0004, 64'h0, 64'hDEAD_BEEF_1234_5678, 1'b0, 3'd2, 8'h00, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 64'h0000_0000_8000_0003, 64'hAB, 64'h0, 1'b0, 3'd0, 8'h08, 64'h0000_0000_AB00_0000, RDP, 1'b0};
    vecs[2]  = '{1'b0, 3'd1, 64'h0000_0000_8000_0001, 64'h0, 64'h0, 1'b1, 3'd0, 8'h00, 64'h0, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 3'd4, 64'h0000_0000_1000_0007, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 3'd0, 8'h00, 64'h0, 64'h80, 1'b1};
    vecs[4]  = '{1'b0, 3'd3, 64'h0000_0000_8000_0008, 64'h0, 64'h8877_6655_4433_2211, 1'b0, 3'd3, 8'h00, 64'h0, 64'h8877_6655_4433_2211, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 64'h0000_0000_8000_0002, 64'h0, 64'h0000_0000_0080_0000, 1'b0, 3'd0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    vecs[6]  = '{1'b0, 3'd5, 64'h0000_0000_8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 1'b0, 3'd1, 8'h00, 64'h0, 64'h0000_0000_0000_BEEF, 1'b0};
    vecs[7]  = '{1'b0, 3'd6, 64'h0000_0000_8000_0000, 64'h0, 64'h1111_1111_F000_0001, 1'b0, 3'd2, 8'h00, 64'h0, 64'h0000_0000_F000_0001, 1'b0};
    vecs[8]  = '{1'b1, 3'd3, 64'h0000_0000_8000_0010, 64'h0102_0304_0506_0708, 64'h0, 1'b0, 3'd3, 8'hFF, 64'h0102_0304_0506_0708, RDP, 1'b0};
    vecs[9]  = '{1'b1, 3'd1, 64'h0000_0000_8000_0006, 64'h1234, 64'h0, 1'b0, 3'd1, 8'hC0, 64'h1234_0000_0000_0000, RDP, 1'b0};
    vecs[10] = '{1'b0, 3'd7, 64'h0000_0000_8000_0000, 64'h0, 64'h0, 1'b1, 3'd0, 8'h00, 64'h0, 64'h0, 1'b0};
    vecs[11] = '{1'b1, 3'd2, 64'h0000_0000_8000_0002, 64'h55, 64'h0, 1'b1, 3'd0, 8'h00, 64'h0, 64'h0, 1'b0};
    vecs[12] = '{1'b0, 3'd1, 64'h0000_0000_8000_0002, 64'h0, 64'h0000_0000_7FFF_0000, 1'b0, 3'd1, 8'h00, 64'h0, 64'h0000_0000_0000_7FFF, 1'b0};
    vecs[13] = '{1'b1, 3'd2, 64'h0000_0000_0000_0004, 64'hCAFE_BABE, 64'h0, 1'b0, 3'd2, 8'hF0, 64'hCAFE_BABE_0000_0000, RDP, 1'b1};

    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; flush_i = 1'b0; info_i = 3'd0;
    addr_i = '0; wdata_i = '0; rd_wdata_i = RDP;
    dresp_addr_ok_i = 1'b0; dresp_data_ok_i = 1'b0; dresp_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(dreq_valid_o), 64'd0);
    chk("rst_stall", 64'(stall_req_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_exc", 64'(exc_o), 64'd0);
    chk("rst_skip", 64'(skip_o), 64'd0);
    chk("rst_addr", dreq_addr_o, 64'd0);
    chk("rst_strobe", 64'(dreq_strobe_o), 64'd0);
    chk("idle_passthru", rd_wdata_o, RDP);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      run_op(vecs[i], i % 3, (i % 4 == 1) ? 1 : 0, 1'b0);

    // Slow slave: address accepted after 3 cycles, data 2 cycles later.
    run_op(vecs[0], 3, 2, 1'b0);

    // Flush while waiting for data, then a normal MMIO load.
    run_op(vecs[6], 0, 2, 1'b1);
    run_op(vecs[3], 1, 0, 1'b0);

    // Flush in IDLE blocks acceptance.
    req_i = 1'b1; we_i = 1'b0; info_i = 3'd2; addr_i = 64'h8000_0000; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", 64'(stall_req_o), 64'd0);
    chk("flush_idle_exc", 64'(exc_o), 64'd0);
    @(posedge clk); #1;
    req_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle_valid", 64'(dreq_valid_o), 64'd0);
    @(posedge clk); #1;

    // Reset while a request is outstanding.
    req_i = 1'b1; we_i = 1'b0; info_i = 3'd2; addr_i = 64'h8000_0004;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_valid", 64'(dreq_valid_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(dreq_valid_o), 64'd0);
    chk("post_rst_stall", 64'(stall_req_o), 64'd0);
    @(posedge clk); #1;
    run_op(vecs[1], 0, 1, 1'b0);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
